// File: rtl/arbitro_prioridade_if.sv
// rtl/arbitro_prioridade_if.sv - request/grant bundle between requesters and the arbiter
interface arbitro_prioridade_if #(
    parameter int N = 4
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          ocupado;
    logic          conflito;

    modport master (
        output req,
        input  gnt,
        input  gnt_idx,
        input  ocupado,
        input  conflito
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_idx,
        output ocupado,
        output conflito
    );
endinterface

// File: rtl/arbitro_prioridade.sv
// rtl/arbitro_prioridade.sv - registered N-channel arbiter, fixed priority or round-robin, bounded hold time
module arbitro_prioridade #(
    parameter int N         = 4,
    parameter int MODO      = 0,
    parameter int MAX_POSSE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    arbitro_prioridade_if.slave  bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(MAX_POSSE + 1);

    typedef enum logic {
        LIVRE,
        CONCEDIDO
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_idx_q, gnt_idx_d;
    logic          ocupado_q, ocupado_d;
    logic          conflito_q, conflito_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  mask_q, mask_d;

    logic [N-1:0]  req_mascarado;
    logic [N-1:0]  candidatos;
    logic [IW-1:0] vencedor;

    function automatic logic [IW-1:0] prox_idx(input logic [IW-1:0] i);
        if (i == IW'(N - 1)) begin
            return '0;
        end
        return i + IW'(1);
    endfunction

    function automatic logic [IW-1:0] escolhe_fixo(input logic [N-1:0] v);
        logic [IW-1:0] r;
        r = '0;
        // Descending scan so the lowest set index is the last assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = IW'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [IW-1:0] escolhe_rr(input logic [N-1:0] v, input logic [IW-1:0] p);
        logic [IW-1:0] r;
        logic [IW-1:0] idx;
        logic          achou;
        r     = '0;
        idx   = p;
        achou = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!achou && v[idx]) begin
                r     = idx;
                achou = 1'b1;
            end
            idx = prox_idx(idx);
        end
        return r;
    endfunction

    function automatic logic mais_de_um(input logic [N-1:0] v);
        return (v & (v - N'(1))) != '0;
    endfunction

    // A timed-out owner is skipped once, unless it is the only requester.
    always_comb begin
        req_mascarado = bus.req & ~mask_q;
        candidatos    = (req_mascarado != '0) ? req_mascarado : bus.req;
        if (MODO == 1) begin
            vencedor = escolhe_rr(candidatos, ptr_q);
        end else begin
            vencedor = escolhe_fixo(candidatos);
        end
    end

    always_comb begin
        estado_d   = estado_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        ocupado_d  = ocupado_q;
        conflito_d = 1'b0;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;

        case (estado_q)
            LIVRE: begin
                if (bus.req != '0) begin
                    estado_d   = CONCEDIDO;
                    gnt_d      = {{(N - 1){1'b0}}, 1'b1} << vencedor;
                    gnt_idx_d  = vencedor;
                    ocupado_d  = 1'b1;
                    conflito_d = mais_de_um(bus.req);
                    cnt_d      = CW'(1);
                    ptr_d      = prox_idx(vencedor);
                    mask_d     = '0;
                end else begin
                    mask_d = '0;
                end
            end
            CONCEDIDO: begin
                if (!bus.req[gnt_idx_q]) begin
                    estado_d  = LIVRE;
                    gnt_d     = '0;
                    ocupado_d = 1'b0;
                    cnt_d     = '0;
                    mask_d    = '0;
                end else if (cnt_q < CW'(MAX_POSSE)) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    estado_d  = LIVRE;
                    gnt_d     = '0;
                    ocupado_d = 1'b0;
                    cnt_d     = '0;
                    mask_d    = gnt_q;
                end
            end
            default: begin
                estado_d = LIVRE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= LIVRE;
            gnt_q      <= '0;
            gnt_idx_q  <= '0;
            ocupado_q  <= 1'b0;
            conflito_q <= 1'b0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            mask_q     <= '0;
        end else begin
            estado_q   <= estado_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            ocupado_q  <= ocupado_d;
            conflito_q <= conflito_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.gnt_idx  = gnt_idx_q;
    assign bus.ocupado  = ocupado_q;
    assign bus.conflito = conflito_q;
endmodule

// File: tb/tb_arbitro_prioridade.sv
// tb/tb_arbitro_prioridade.sv - directed bench for arbitro_prioridade in fixed and round-robin modes
module tb_arbitro_prioridade;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    arbitro_prioridade_if #(.N(4)) if_f ();
    arbitro_prioridade_if #(.N(4)) if_r ();

    arbitro_prioridade #(.N(4), .MODO(0), .MAX_POSSE(4)) u_fixo (
        .clk (clk),
        .rst (rst),
        .bus (if_f)
    );

    arbitro_prioridade #(.N(4), .MODO(1), .MAX_POSSE(4)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_r)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] tab_fixo_g [0:10] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                      4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0010};
    logic       tab_fixo_c [0:10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        if_f.req = 4'b0000;
        if_r.req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] eg;
        int         dono;

        // reset held with all requests active
        rst      = 1'b1;
        if_f.req = 4'b1111;
        if_r.req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_gnt_%0d", i), 32'(if_f.gnt), 32'h0);
            check($sformatf("rst_ocup_%0d", i), 32'(if_f.ocupado), 32'h0);
            check($sformatf("rst_conf_%0d", i), 32'(if_f.conflito), 32'h0);
            check($sformatf("rst_idx_%0d", i), 32'(if_r.gnt_idx), 32'h0);
        end
        rst = 1'b0;
        tick();
        check("pos_rst_gnt_f", 32'(if_f.gnt), 32'h1);
        check("pos_rst_conf_f", 32'(if_f.conflito), 32'h1);
        check("pos_rst_gnt_r", 32'(if_r.gnt), 32'h1);
        check("pos_rst_conf_r", 32'(if_r.conflito), 32'h1);

        // fixed priority with timeout and one-shot mask
        do_reset();
        if_f.req = 4'b0110;
        for (int t = 0; t < 11; t++) begin
            tick();
            check($sformatf("fixo_gnt_%0d", t), 32'(if_f.gnt), 32'(tab_fixo_g[t]));
            check($sformatf("fixo_conf_%0d", t), 32'(if_f.conflito), 32'(tab_fixo_c[t]));
            check($sformatf("fixo_ocup_%0d", t), 32'(if_f.ocupado), 32'(|tab_fixo_g[t]));
        end

        // round-robin rotation with idle gaps and 3->0 wrap
        do_reset();
        if_r.req = 4'b1111;
        for (int t = 0; t < 21; t++) begin
            tick();
            dono = (t / 5) % 4;
            eg   = ((t % 5) < 4) ? (4'b0001 << dono) : 4'b0000;
            check($sformatf("rr_gnt_%0d", t), 32'(if_r.gnt), 32'(eg));
            check($sformatf("rr_idx_%0d", t), 32'(if_r.gnt_idx), 32'(dono));
        end

        // voluntary release after a 2-cycle request
        do_reset();
        if_f.req = 4'b0100;
        tick();
        check("vol_gnt_1", 32'(if_f.gnt), 32'h4);
        check("vol_conf_1", 32'(if_f.conflito), 32'h0);
        tick();
        check("vol_gnt_2", 32'(if_f.gnt), 32'h4);
        if_f.req = 4'b0000;
        tick();
        check("vol_gnt_3", 32'(if_f.gnt), 32'h0);
        check("vol_idx_3", 32'(if_f.gnt_idx), 32'h2);
        tick();
        check("vol_idx_4", 32'(if_f.gnt_idx), 32'h2);
        check("vol_ocup_4", 32'(if_f.ocupado), 32'h0);

        // non-owner toggling during a grant
        do_reset();
        if_f.req = 4'b0010;
        tick();
        check("nao_dono_gnt_1", 32'(if_f.gnt), 32'h2);
        if_f.req = 4'b1011;
        tick();
        check("nao_dono_gnt_2", 32'(if_f.gnt), 32'h2);
        check("nao_dono_conf_2", 32'(if_f.conflito), 32'h0);
        if_f.req = 4'b0010;
        tick();
        check("nao_dono_gnt_3", 32'(if_f.gnt), 32'h2);
        if_f.req = 4'b1011;
        tick();
        check("nao_dono_gnt_4", 32'(if_f.gnt), 32'h2);
        tick();
        check("nao_dono_timeout", 32'(if_f.gnt), 32'h0);
        tick();
        check("nao_dono_mask_gnt", 32'(if_f.gnt), 32'h1);
        check("nao_dono_mask_conf", 32'(if_f.conflito), 32'h1);

        // reset mid-grant restores round-robin pointer
        do_reset();
        if_r.req = 4'b0010;
        tick();
        check("rst_meio_gnt_1", 32'(if_r.gnt), 32'h2);
        rst = 1'b1;
        tick();
        check("rst_meio_gnt_0", 32'(if_r.gnt), 32'h0);
        check("rst_meio_idx_0", 32'(if_r.gnt_idx), 32'h0);
        rst      = 1'b0;
        if_r.req = 4'b1111;
        tick();
        check("rst_meio_primeiro", 32'(if_r.gnt), 32'h1);
        check("rst_meio_idx", 32'(if_r.gnt_idx), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
